// File: rtl/candidate_dispatcher_pkg.sv
// Shared types and defaults for the candidate dispatch / index mapping blocks.
package candidate_dispatcher_pkg;

    localparam int BS_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_NONE = 2'd2
    } disp_state_t;

endpackage

// File: rtl/candidate_dispatcher_if.sv
// Handshake bundle between a candidate-list producer/consumer and the dispatcher.
interface candidate_dispatcher_if
    import candidate_dispatcher_pkg::*;
#(
    parameter int BS = BS_DEFAULT
);
    localparam int IW = $clog2(BS);

    logic          in_valid;
    logic          in_ready;
    logic [0:BS-1] candidate_list;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_index;
    logic          out_last;
    logic [IW:0]   out_count;
    logic          out_none;

    // master: the environment around the dispatcher; slave: the dispatcher itself
    modport master (
        output in_valid, candidate_list, flush, out_ready,
        input  in_ready, out_valid, out_index, out_last, out_count, out_none
    );

    modport slave (
        input  in_valid, candidate_list, flush, out_ready,
        output in_ready, out_valid, out_index, out_last, out_count, out_none
    );

endinterface

// File: rtl/candidate_dispatcher_lowest_set_index.sv
// Combinational priority pick of the lowest set index in a mask (bit 0 leftmost).
module lowest_set_index
    import candidate_dispatcher_pkg::*;
#(
    parameter  int BS = BS_DEFAULT,
    localparam int IW = $clog2(BS)
) (
    input  logic [0:BS-1] mask,
    output logic [IW-1:0] index,
    output logic          any
);

    // Scan high to low so the last hit (lowest index) wins.
    always_comb begin
        index = '0;
        any   = 1'b0;
        for (int i = BS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                index = IW'(i);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/candidate_dispatcher.sv
// Accepts a candidate bitmap and emits its set indices in ascending order, one per beat.
module candidate_dispatcher
    import candidate_dispatcher_pkg::*;
#(
    parameter  int BS = BS_DEFAULT,
    localparam int IW = $clog2(BS)
) (
    input logic                   clk,
    input logic                   rst,
    candidate_dispatcher_if.slave bus
);

    disp_state_t   state, state_nxt;
    logic [0:BS-1] pending;
    logic [0:BS-1] pending_rest;
    logic [IW:0]   count_q;
    logic [IW:0]   list_pop;
    logic [IW-1:0] low_idx;
    logic          any_set;
    logic          is_last;
    logic          in_hs;
    logic          out_hs;
    logic          list_nz;

    lowest_set_index #(.BS(BS)) u_lsi (
        .mask  (pending),
        .index (low_idx),
        .any   (any_set)
    );

    // IW+1 bits so an all-ones list reports BS without wrapping.
    always_comb begin
        list_pop = '0;
        for (int i = 0; i < BS; i++) begin
            list_pop = list_pop + (IW + 1)'(bus.candidate_list[i]);
        end
    end

    always_comb begin
        pending_rest          = pending;
        pending_rest[low_idx] = 1'b0;
    end

    assign list_nz = |bus.candidate_list;
    assign is_last = any_set && (pending_rest == '0);
    assign in_hs   = bus.in_valid && bus.in_ready;
    assign out_hs  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_hs) state_nxt = list_nz ? ST_EMIT : ST_NONE;
            ST_EMIT: if (bus.flush || (out_hs && is_last)) state_nxt = ST_IDLE;
            ST_NONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are zeroed outside EMIT so consumers never see stale index data.
    always_comb begin
        bus.in_ready  = rst && (state == ST_IDLE);
        bus.out_valid = (state == ST_EMIT);
        bus.out_none  = (state == ST_NONE);
        bus.out_index = '0;
        bus.out_last  = 1'b0;
        bus.out_count = '0;
        if (state == ST_EMIT) begin
            bus.out_index = low_idx;
            bus.out_last  = is_last;
            bus.out_count = count_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            count_q <= '0;
        end else begin
            case (state)
                ST_IDLE: if (in_hs) begin
                    pending <= bus.candidate_list;
                    count_q <= list_pop;
                end
                ST_EMIT: begin
                    if (bus.flush)  pending <= '0;
                    else if (out_hs) pending <= pending_rest;
                end
                default: pending <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_candidate_dispatcher.sv
// Scenario bench for candidate_dispatcher with a beat scoreboard.
module tb_candidate_dispatcher;
    localparam int BS = 16;
    localparam int IW = $clog2(BS);

    typedef struct {
        logic [IW-1:0] idx;
        logic          last;
        logic [IW:0]   cnt;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    beat_t exp_q[$];

    candidate_dispatcher_if #(.BS(BS)) bus ();

    candidate_dispatcher #(.BS(BS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: every delivered beat must match the next expected one.
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: got idx=%0d, required no beat", bus.out_index);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                if (bus.out_index !== e.idx || bus.out_last !== e.last || bus.out_count !== e.cnt) begin
                    n_fail++;
                    $display("FAIL beat: got idx=%0d last=%0b cnt=%0d, required idx=%0d last=%0b cnt=%0d",
                             bus.out_index, bus.out_last, bus.out_count, e.idx, e.last, e.cnt);
                end
            end
        end
    end

    task automatic push_list(input logic [0:BS-1] l);
        int c;
        int hi;
        beat_t b;
        c  = 0;
        hi = -1;
        for (int i = 0; i < BS; i++) if (l[i]) begin c++; hi = i; end
        for (int i = 0; i < BS; i++) if (l[i]) begin
            b.idx  = IW'(i);
            b.last = (i == hi);
            b.cnt  = (IW + 1)'(c);
            exp_q.push_back(b);
        end
    endtask

    task automatic send_list(input logic [0:BS-1] l);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        bus.in_valid       = 1'b1;
        bus.candidate_list = l;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1; break; end
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1");
        end
        @(posedge clk); #1;
        bus.in_valid       = 1'b0;
        bus.candidate_list = '0;
    endtask

    task automatic wait_drain(input string name);
        bit ok;
        ok = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) begin ok = 1; break; end
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_none !== 1'b0 ||
            bus.out_index !== '0 || bus.out_count !== '0 || bus.out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%0b vld=%0b none=%0b, required all 0",
                     bus.in_ready, bus.out_valid, bus.out_none);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %0b, required 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        logic [0:BS-1] l;
        l = '0; l[2] = 1'b1; l[5] = 1'b1; l[15] = 1'b1;
        bus.out_ready = 1'b1;
        push_list(l);
        send_list(l);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++;
            if (bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_consecutive[%0d]: out_valid=%0b, required 1", k, bus.out_valid);
            end
        end
        @(negedge clk);
        n_chk++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: rdy=%0b vld=%0b, required rdy=1 vld=0", bus.in_ready, bus.out_valid);
        end
        wait_drain("basic");
    endtask

    task automatic test_all_ones();
        logic [0:BS-1] l;
        l = '1;
        bus.out_ready = 1'b1;
        push_list(l);
        send_list(l);
        for (int k = 0; k < BS; k++) begin
            @(negedge clk);
            n_chk++;
            if (bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL ones_consecutive[%0d]: out_valid=%0b, required 1", k, bus.out_valid);
            end
        end
        wait_drain("ones");
    endtask

    task automatic test_none();
        bus.out_ready = 1'b1;
        send_list('0);
        @(negedge clk);
        n_chk++;
        if (bus.out_none !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL none_pulse: none=%0b vld=%0b rdy=%0b, required 1 0 0",
                     bus.out_none, bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        n_chk++;
        if (bus.out_none !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL none_after: none=%0b rdy=%0b vld=%0b, required 0 1 0",
                     bus.out_none, bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [0:BS-1] l;
        l = '0; l[3] = 1'b1; l[9] = 1'b1;
        bus.out_ready = 1'b0;
        push_list(l);
        send_list(l);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_chk++;
            if (bus.out_valid !== 1'b1 || bus.out_index !== 4'd3 || bus.out_last !== 1'b0 ||
                bus.out_count !== 5'd2) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: vld=%0b idx=%0d last=%0b cnt=%0d, required 1 3 0 2",
                         k, bus.out_valid, bus.out_index, bus.out_last, bus.out_count);
            end
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        wait_drain("stall");
    endtask

    task automatic test_flush();
        logic [0:BS-1] l;
        beat_t b;
        l = '0; l[1] = 1'b1; l[4] = 1'b1; l[7] = 1'b1;
        bus.out_ready = 1'b1;
        b.idx = 4'd1; b.last = 1'b0; b.cnt = 5'd3; exp_q.push_back(b);
        b.idx = 4'd4; b.last = 1'b0; b.cnt = 5'd3; exp_q.push_back(b);
        send_list(l);
        @(posedge clk); #1 bus.flush = 1'b1;
        @(negedge clk);
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.out_index !== 4'd4) begin
            n_fail++;
            $display("FAIL flush_beat: vld=%0b idx=%0d, required 1 4", bus.out_valid, bus.out_index);
        end
        @(posedge clk); #1 bus.flush = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_idle: vld=%0b rdy=%0b, required 0 1", bus.out_valid, bus.in_ready);
        end
        repeat (3) @(negedge clk);
        wait_drain("flush");
    endtask

    task automatic test_reset_mid();
        logic [0:BS-1] l;
        l = '0; l[0] = 1'b1; l[8] = 1'b1;
        bus.out_ready = 1'b0;
        send_list(l);
        @(negedge clk);
        n_chk++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: vld=%0b, required 1", bus.out_valid);
        end
        #1 rst = 1'b0;
        #1;
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_now: vld=%0b rdy=%0b, required 0 0", bus.out_valid, bus.in_ready);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_release: rdy=%0b vld=%0b, required 1 0", bus.in_ready, bus.out_valid);
        end
        l = '0; l[0] = 1'b1;
        push_list(l);
        send_list(l);
        wait_drain("rstmid");
    endtask

    initial begin
        bus.in_valid       = 1'b0;
        bus.candidate_list = '0;
        bus.flush          = 1'b0;
        bus.out_ready      = 1'b0;
        test_reset();
        test_basic();
        test_all_ones();
        test_none();
        test_backpressure();
        test_flush();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

endmodule
